alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_if.sv | 30 +++
 rtl/alu_comb_unit.sv | 31 +++
 rtl/alu_iter.sv | 106 ++++++++++
 tb/tb_alu_iter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU and its control decoder.
//   alu_op_e    : 4-bit operation codes driven on alu_control
//   alu_state_e : sequencer states (idle vs. multi-cycle shift)
//   is_shift_op : true for the codes that iterate one bit per cycle
package alu_pkg;

    localparam int unsigned OpW = 4;

    typedef enum logic [OpW-1:0] {
        OpAnd = 4'd0,
        OpOr  = 4'd1,
        OpAdd = 4'd2,
        OpSll = 4'd3,
        OpSrl = 4'd4,
        OpSub = 4'd6,
        OpSlt = 4'd7
    } alu_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input logic [OpW-1:0] op);
        return (op == OpSll) || (op == OpSrl);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/result bundle of the iterative ALU.
//   master : drives start, abort, alu_control, operand_a, operand_b;
//            observes alu_out, zero, busy, done
//   slave  : the ALU side (directions reversed)
interface alu_iter_if #(
    parameter int unsigned DATA_W = 32
);
    import alu_pkg::*;

    logic              start;
    logic              abort;
    logic [OpW-1:0]    alu_control;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_out;
    logic              zero;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, alu_control, operand_a, operand_b,
        input  alu_out, zero, busy, done
    );

    modport slave (
        input  start, abort, alu_control, operand_a, operand_b,
        output alu_out, zero, busy, done
    );

endinterface

// File: rtl/alu_comb_unit.sv
// Combinational single-cycle datapath of the iterative ALU.
//   op_i     : operation code (alu_pkg::alu_op_e values)
//   a_i, b_i : operands
//   result_o : result; 0 for undefined codes
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OpW-1:0]    op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OpAnd: result_o = a_i & b_i;
            OpOr:  result_o = a_i | b_i;
            OpAdd: result_o = a_i + b_i;
            OpSub: result_o = a_i - b_i;
            OpSlt: result_o[0] = $signed(a_i) < $signed(b_i);
            // Only reached for a zero shift amount; non-zero shifts iterate in the top.
            OpSll,
            OpSrl: result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: logic/arithmetic ops complete in one cycle, shifts by n>0
// take one cycle per bit position and can be aborted while in flight.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_iter_if slave (start/abort/opcode/operands in;
//           alu_out/zero/busy/done out)
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_iter_if.slave bus
);

    localparam int unsigned ShW = $clog2(DATA_W);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ShW-1:0]    cnt_q, cnt_d;
    logic              dir_right_q, dir_right_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] comb_result;
    logic [ShW-1:0]    shamt;
    logic [DATA_W-1:0] acc_shifted;

    alu_comb_unit #(
        .DATA_W (DATA_W)
    ) u_comb (
        .op_i     (bus.alu_control),
        .a_i      (bus.operand_a),
        .b_i      (bus.operand_b),
        .result_o (comb_result)
    );

    assign shamt       = bus.operand_b[ShW-1:0];
    assign acc_shifted = dir_right_q ? (acc_q >> 1) : (acc_q << 1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dir_right_d = dir_right_q;
        alu_out_d   = alu_out_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort is meaningless here; start alone decides
                if (bus.start) begin
                    if (is_shift_op(bus.alu_control) && (shamt != '0)) begin
                        acc_d       = bus.operand_a;
                        cnt_d       = shamt;
                        dir_right_d = (bus.alu_control == OpSrl);
                        state_d     = StShift;
                    end else begin
                        alu_out_d = comb_result;
                        done_d    = 1'b1;
                    end
                end
            end
            StShift: begin
                // abort wins over the completing shift; alu_out is left alone
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_shifted;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ShW'(1)) begin
                        alu_out_d = acc_shifted;
                        done_d    = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            alu_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dir_right_q <= dir_right_d;
            alu_out_q   <= alu_out_d;
            done_q      <= done_d;
        end
    end

    assign bus.alu_out = alu_out_q;
    assign bus.zero    = (alu_out_q == '0);
    assign bus.busy    = (state_q == StShift);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_alu_iter;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_iter_if #(.DATA_W(DW)) bus ();

    alu_iter #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_out = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: return a << b[4:0];
            4'd4: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input logic exp_done, input logic exp_busy);
        check_val({tag, ".done"}, 32'(bus.done), 32'(exp_done));
        check_val({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
        check_val({tag, ".alu_out"}, bus.alu_out, exp_out);
        check_val({tag, ".zero"}, 32'(bus.zero), 32'(exp_out == 32'd0));
    endtask

    // Called at a negedge; returns at the negedge of the last observed cycle.
    // abort_at: cycle (1-based after start) in which abort is driven, -1 for none.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int abort_at, input bit poke_busy,
                          input bit abort_w_start);
        bit   is_sh;
        int   sh;
        int   lat;
        int   last;
        bit   aborted;
        logic [31:0] res;
        logic exp_done;
        logic exp_busy;

        is_sh   = (op == 4'd3) || (op == 4'd4);
        sh      = int'(b[4:0]);
        lat     = (is_sh && sh != 0) ? sh + 1 : 1;
        res     = ref_result(op, a, b);
        aborted = (abort_at >= 1) && (abort_at < lat);
        last    = aborted ? abort_at + 2 : lat;

        bus.start       = 1'b1;
        bus.abort       = abort_w_start;
        bus.alu_control = op;
        bus.operand_a   = a;
        bus.operand_b   = b;

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            bus.start       = 1'b0;
            bus.abort       = 1'b0;
            bus.alu_control = 4'($urandom);
            bus.operand_a   = $urandom;
            bus.operand_b   = $urandom;

            exp_done = !aborted && (c == lat);
            exp_busy = aborted ? (c <= abort_at) : (c < lat);
            if (exp_done) exp_out = res;
            check_outputs(tag, exp_done, exp_busy);

            if (aborted && c == abort_at) bus.abort = 1'b1;
            else if (poke_busy && exp_busy && $urandom_range(0, 1) == 1) bus.start = 1'b1;
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.alu_control = '0;
        bus.operand_a   = '0;
        bus.operand_b   = '0;

        // Reset, with start/abort asserted to show reset overrides them.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        bus.operand_a = 32'hdead_beef;
        @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_outputs("idle", 1'b0, 1'b0);

        run_op("sub",      4'd6, 32'd5,          32'd7,        -1, 1'b0, 1'b0);
        run_op("add_wrap", 4'd2, 32'hffff_ffff,  32'd1,        -1, 1'b0, 1'b0);
        run_op("slt_neg",  4'd7, 32'hffff_fffe,  32'd1,        -1, 1'b0, 1'b0);
        run_op("sll5",     4'd3, 32'd1,          32'h25,       -1, 1'b1, 1'b0);
        run_op("srl31",    4'd4, 32'h8000_0000,  32'd31,       -1, 1'b1, 1'b0);
        run_op("srl0",     4'd4, 32'h1234_5678,  32'd0,        -1, 1'b0, 1'b0);
        run_op("sll0_hi",  4'd3, 32'h0000_00a5,  32'h0000_0100, -1, 1'b0, 1'b0);
        run_op("sll_abrt", 4'd3, 32'h0000_0003,  32'd10,        3, 1'b0, 1'b0);
        run_op("undef5",   4'd5, 32'hffff_ffff,  32'hffff_ffff, -1, 1'b0, 1'b0);
        run_op("or",       4'd1, 32'h00f0_0000,  32'h0000_000f, -1, 1'b0, 1'b1);
        run_op("undef9",   4'd9, 32'h1,          32'h2,         -1, 1'b0, 1'b0);
        run_op("and",      4'd0, 32'hf0f0_f0f0,  32'hff00_ff00, -1, 1'b0, 1'b0);
        run_op("srl_abrt", 4'd4, 32'hffff_ffff,  32'd4,         4, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          ab;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'd4;
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            ab = -1;
            if ($urandom_range(0, 3) == 0 && b[4:0] != 5'd0) ab = $urandom_range(1, int'(b[4:0]));
            run_op("rand", op, a, b, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a shift: outputs clear, no done afterwards.
        run_op("pre_rst", 4'd1, 32'h0000_1234, 32'd0, -1, 1'b0, 1'b0);
        bus.start       = 1'b1;
        bus.alu_control = 4'd3;
        bus.operand_a   = 32'd3;
        bus.operand_b   = 32'd20;
        @(negedge clk);
        bus.start = 1'b0;
        check_outputs("pre_rst_shift", 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_out = 32'd0;
        check_outputs("rst_mid", 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            check_outputs("post_rst", 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
